// File: rtl/rr_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin register arbiter.
//   id_width()  : width of a requester index, at least one bit
//   req_id_t    : requester index at the default requester count
//   state_e     : register occupancy, EMPTY or FULL
package rr_reg_arbiter_pkg;

   localparam int unsigned num_req_dflt_lp = 4;
   localparam int unsigned width_dflt_lp   = 8;

   // A single requester still carries a 1-bit index so id_o never collapses
   // to zero width.
   function automatic int unsigned id_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned id_w_dflt_lp = id_width(num_req_dflt_lp);

   typedef logic [id_w_dflt_lp-1:0] req_id_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

endpackage

// File: rtl/rr_reg_arbiter_arb.sv
// Combinational round-robin arbiter.
//   req       : request vector, one bit per requester
//   ptr       : highest-priority requester index this cycle
//   grant     : one-hot grant, all zero when nobody requests
//   grant_id  : encoded index of the granted requester (0 when no grant)
//   any_grant : at least one requester is granted
module rr_arb
   import rr_reg_arbiter_pkg::*;
#(
   parameter int unsigned num_req_p = 4,
   parameter int unsigned id_w_lp   = id_width(num_req_p)
) (
   input  logic [num_req_p-1:0] req,
   input  logic [id_w_lp-1:0]   ptr,
   output logic [num_req_p-1:0] grant,
   output logic [id_w_lp-1:0]   grant_id,
   output logic                 any_grant
);

   // Two-pass scan: first the requesters at or above ptr, then the ones
   // below it. This gives the wrapping order ptr, ptr+1, ... without a
   // modulo on a variable index.
   always_comb begin
      grant     = '0;
      grant_id  = '0;
      any_grant = 1'b0;
      for (int k = 0; k < int'(num_req_p); k++) begin
         if (!any_grant && req[k] && (k >= int'(ptr))) begin
            any_grant = 1'b1;
            grant[k]  = 1'b1;
            grant_id  = id_w_lp'(k);
         end
      end
      for (int k = 0; k < int'(num_req_p); k++) begin
         if (!any_grant && req[k]) begin
            any_grant = 1'b1;
            grant[k]  = 1'b1;
            grant_id  = id_w_lp'(k);
         end
      end
   end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter in front of a single enabled register stage.
// Several producers compete for one register; the winner's word is captured
// and held until the consumer takes it. The register refills in the same
// cycle it drains, so a busy stream moves one word per cycle.
//   clk_i    : clock
//   reset_i  : synchronous active-high reset
//   valid_i  : per-requester valid
//   data_i   : requester k data at [k*width_p +: width_p]
//   ready_o  : per-requester accept, at most one bit high
//   valid_o  : register holds an unconsumed word
//   data_o   : registered word
//   id_o     : requester that supplied the registered word
//   ready_i  : consumer takes data_o this cycle
module rr_reg_arbiter
   import rr_reg_arbiter_pkg::*;
#(
   parameter int unsigned num_req_p = 4,
   parameter int unsigned width_p   = 8,
   parameter int unsigned id_w_lp   = id_width(num_req_p)
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic [num_req_p-1:0]           valid_i,
   input  logic [num_req_p*width_p-1:0]   data_i,
   output logic [num_req_p-1:0]           ready_o,
   output logic                           valid_o,
   output logic [width_p-1:0]             data_o,
   output logic [id_w_lp-1:0]             id_o,
   input  logic                           ready_i
);

   state_e                              state_r;
   logic [id_w_lp-1:0]                  ptr_r;
   logic [width_p-1:0]                  data_r;
   logic [id_w_lp-1:0]                  id_r;

   logic [num_req_p-1:0][width_p-1:0]   data_arr;
   logic [num_req_p-1:0]                grant;
   logic [id_w_lp-1:0]                  grant_id;
   logic                                any_grant;
   logic                                full_r;
   logic                                slot_free;
   logic                                accept;
   logic [width_p-1:0]                  win_data;
   logic [id_w_lp-1:0]                  ptr_nxt;

   assign data_arr = data_i;
   assign full_r   = (state_r == FULL);

   rr_arb #(
      .num_req_p (num_req_p),
      .id_w_lp   (id_w_lp)
   ) u_arb (
      .req       (valid_i),
      .ptr       (ptr_r),
      .grant     (grant),
      .grant_id  (grant_id),
      .any_grant (any_grant)
   );

   // A full register that is being drained this cycle counts as free.
   assign slot_free = !full_r || ready_i;
   assign accept    = !reset_i && slot_free && any_grant;
   assign ready_o   = accept ? grant : '0;

   // Grant is one-hot, so an AND-OR select is enough to pick the word.
   always_comb begin
      win_data = '0;
      for (int k = 0; k < int'(num_req_p); k++) begin
         if (grant[k]) win_data = win_data | data_arr[k];
      end
   end

   // Priority moves to the requester after the winner, wrapping at the top.
   // With one requester this is always 0.
   assign ptr_nxt = (grant_id == id_w_lp'(num_req_p - 1)) ? '0
                                                          : grant_id + 1'b1;

   // Occupancy and priority pointer. The pointer only moves on accept, so
   // idle and stalled cycles keep the current priority.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= EMPTY;
         ptr_r   <= '0;
      end else begin
         case (state_r)
            EMPTY: begin
               if (accept) begin
                  state_r <= FULL;
                  ptr_r   <= ptr_nxt;
               end
            end
            FULL: begin
               if (accept) begin
                  ptr_r <= ptr_nxt;
               end else if (ready_i) begin
                  state_r <= EMPTY;
               end
            end
            default: state_r <= EMPTY;
         endcase
      end
   end

   // Data/id register, loaded only on accept. After a drain it keeps the
   // last word, which is harmless because valid_o is low.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         data_r <= '0;
         id_r   <= '0;
      end else if (accept) begin
         data_r <= win_data;
         id_r   <= grant_id;
      end
   end

   assign valid_o = full_r;
   assign data_o  = data_r;
   assign id_o    = id_r;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
module tb_rr_reg_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic              clk;
   logic              reset_i;
   logic [N-1:0]      valid_i;
   logic [N*W-1:0]    data_i;
   logic [N-1:0]      ready_o;
   logic              valid_o;
   logic [W-1:0]      data_o;
   logic [1:0]        id_o;
   logic              ready_i;

   int checks   = 0;
   int failures = 0;

   rr_reg_arbiter #(.num_req_p(N), .width_p(W)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .valid_i (valid_i),
      .data_i  (data_i),
      .ready_o (ready_o),
      .valid_o (valid_o),
      .data_o  (data_o),
      .id_o    (id_o),
      .ready_i (ready_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { int id; logic [W-1:0] data; } ent_t;
   ent_t          sb[$];
   bit            model_ok = 1'b0;
   bit            m_full   = 1'b0;
   int            m_ptr    = 0;
   int            m_id     = 0;
   logic [W-1:0]  m_data   = '0;

   // First requester with valid set, scanning from p upward with wrap.
   function automatic int winner(input logic [N-1:0] v, input int p);
      for (int i = 0; i < N; i++)
         if (v[(p + i) % N]) return (p + i) % N;
      return -1;
   endfunction

   function automatic logic [W-1:0] word_of(input int k);
      logic [N*W-1:0] d;
      d = data_i;
      return d[k*W +: W];
   endfunction

   always @(posedge clk) begin
      if (reset_i) begin
         model_ok <= 1'b1;
         m_full   <= 1'b0;
         m_ptr    <= 0;
         m_id     <= 0;
         m_data   <= '0;
         sb.delete();
      end else if (model_ok) begin
         if (m_full && ready_i) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL sb_underflow actual=consume expected=empty_queue at %0t", $time);
            end else begin
               ent_t e;
               e = sb.pop_front();
               chk("sb_id", 32'(id_o), 32'(e.id));
               chk("sb_data", 32'(data_o), 32'(e.data));
            end
         end
         if (winner(valid_i, m_ptr) >= 0 && (!m_full || ready_i)) begin
            sb.push_back('{id: winner(valid_i, m_ptr), data: word_of(winner(valid_i, m_ptr))});
            m_full <= 1'b1;
            m_id   <= winner(valid_i, m_ptr);
            m_data <= word_of(winner(valid_i, m_ptr));
            m_ptr  <= (winner(valid_i, m_ptr) + 1) % N;
         end else if (m_full && ready_i) begin
            m_full <= 1'b0;
         end
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (model_ok) begin
         logic [N-1:0] exp_rdy;
         exp_rdy = '0;
         if (!reset_i && (!m_full || ready_i) && winner(valid_i, m_ptr) >= 0)
            exp_rdy[winner(valid_i, m_ptr)] = 1'b1;
         chk("cyc_ready", 32'(ready_o), 32'(exp_rdy));
         chk("cyc_valid", 32'(valid_o), 32'(m_full));
         chk("cyc_data", 32'(data_o), 32'(m_data));
         chk("cyc_id", 32'(id_o), 32'(m_id));
      end
      checks++;
      if (!$onehot0(ready_o)) begin
         failures++;
         $display("FAIL onehot_ready actual=%b expected=onehot0 at %0t", ready_o, $time);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int k, input logic [W-1:0] v);
      data_i[k*W +: W] = v;
   endtask

   task automatic chk_out(input string name, input int v, input int id, input int d);
      chk({name, "_valid"}, 32'(valid_o), 32'(v));
      chk({name, "_id"}, 32'(id_o), 32'(id));
      chk({name, "_data"}, 32'(data_o), 32'(d));
   endtask

   initial begin
      reset_i = 1'b1;
      valid_i = 4'b1111;
      ready_i = 1'b1;
      data_i  = '0;
      for (int k = 0; k < N; k++) set_data(k, 8'(8'h10 + k));

      // 1. reset
      tick; tick;
      chk("rst_ready", 32'(ready_o), 32'h0);
      chk_out("rst", 0, 0, 0);
      reset_i = 1'b0;
      #1;
      chk("rel_ready", 32'(ready_o), 32'b0001);

      // 2. round-robin at full rate
      tick; chk_out("rr0", 1, 0, 'h10);
      tick; chk_out("rr1", 1, 1, 'h11);
      tick; chk_out("rr2", 1, 2, 'h12);
      tick; chk_out("rr3", 1, 3, 'h13);
      tick; chk_out("rr4", 1, 0, 'h10);
      valid_i = 4'b0000;
      tick; chk("rr_drain_valid", 32'(valid_o), 32'h0);

      // 3. skip and wrap from ptr=3
      valid_i = 4'b0100;
      tick; chk_out("sk_pre", 1, 2, 'h12);
      valid_i = 4'b0101;
      #1;
      chk("sk_ready_wrap", 32'(ready_o), 32'b0001);
      tick; chk_out("sk0", 1, 0, 'h10);
      chk("sk_ready_next", 32'(ready_o), 32'b0100);
      tick; chk_out("sk2", 1, 2, 'h12);

      // 4. backpressure
      set_data(1, 8'hA5);
      valid_i = 4'b0010;
      #1;
      chk("bp_ready_req1", 32'(ready_o), 32'b0010);
      tick; chk_out("bp_acc", 1, 1, 'hA5);
      ready_i = 1'b0;
      valid_i = 4'b1111;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_stall_ready", 32'(ready_o), 32'h0);
         tick;
         chk_out("bp_stall", 1, 1, 'hA5);
      end
      ready_i = 1'b1;
      #1;
      chk("bp_refill_ready", 32'(ready_o), 32'b0100);
      tick; chk_out("bp_refill", 1, 2, 'h12);

      // 5. drain to empty, priority held through idle cycles
      valid_i = 4'b0000;
      tick; chk("dr_valid", 32'(valid_o), 32'h0);
      tick; tick;
      chk_out("dr_idle", 0, 2, 'h12);
      valid_i = 4'b1111;
      #1;
      chk("dr_ptr_kept", 32'(ready_o), 32'b1000);
      tick; chk_out("dr_acc", 1, 3, 'h13);

      // 6. reset while stalled
      valid_i = 4'b0010;
      #1;
      chk("rs_ready", 32'(ready_o), 32'b0010);
      tick; chk_out("rs_acc", 1, 1, 'hA5);
      valid_i = 4'b0000;
      ready_i = 1'b0;
      tick; chk_out("rs_stall", 1, 1, 'hA5);
      reset_i = 1'b1;
      valid_i = 4'b1111;
      #1;
      chk("rs_ready_in_reset", 32'(ready_o), 32'h0);
      tick; chk_out("rs_after", 0, 0, 0);
      reset_i = 1'b0;
      ready_i = 1'b1;
      #1;
      chk("rs_ptr_zero", 32'(ready_o), 32'b0001);
      tick; chk_out("rs_first", 1, 0, 'h10);
      valid_i = 4'b0000;
      tick; tick;
      chk("end_valid", 32'(valid_o), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
